// File: rtl/data_memory_ls.sv
// Byte-addressable 32-bit data memory with sized, sign/zero-extending loads and
// a READ_LAT-deep read pipeline. Define DMEM_CLEAR_EN to zero the array after reset.
module data_memory_ls #(
  parameter int DEPTH_WORDS = 128,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  input  logic        W,
  input  logic        R,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] DataOut,
  output logic        Valid,
  output logic        Misaligned,
  output logic        Busy
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]       mem [DEPTH_WORDS];
  logic [AW-1:0]     idx;
  logic              busy;
  logic              accept;
  logic              mis;
  logic              st_ok;
  logic              ld_ok;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [3:0]        we_be;
  logic [31:0]       we_data;
  logic [AW-1:0]     we_idx;
  logic              clr_we;
  logic [AW-1:0]     clr_idx;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       rd_ext;
  logic              unused_addr;

  logic [READ_LAT-1:0] pv_q, pv_d;
  logic [31:0]         pd_q [READ_LAT];
  logic [31:0]         pd_d [READ_LAT];
  logic                mis_q, mis_d;

  assign idx         = Address[AW+1:2];
  assign unused_addr = ^{Address[31:AW+2]};

`ifdef DMEM_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {AW{1'b1}}) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == CLEAR);
  assign clr_we  = (state_q == CLEAR);
  assign clr_idx = cnt_q;
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  assign accept = (W | R) & ~busy & rst_n;
  assign mis    = (Size == 2'b11) || (Size == 2'b01 && Address[0]) ||
                  (Size == 2'b10 && Address[1:0] != 2'b00);
  assign st_ok  = accept & W & ~mis;
  assign ld_ok  = accept & R & ~mis;

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    st_be   = 4'b0000;
    st_data = DataIn;
    case (Size)
      2'b00: begin
        st_be   = 4'b0001 << Address[1:0];
        st_data = {4{DataIn[7:0]}};
      end
      2'b01: begin
        st_be   = Address[1] ? 4'b1100 : 4'b0011;
        st_data = {2{DataIn[15:0]}};
      end
      2'b10:   st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  always_comb begin
    we_be   = st_ok ? st_be : 4'b0000;
    we_data = st_data;
    we_idx  = idx;
    if (clr_we) begin
      we_be   = 4'b1111;
      we_data = '0;
      we_idx  = clr_idx;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_be[b]) mem[we_idx][8*b +: 8] <= we_data[8*b +: 8];
    end
  end

  // Read samples the array before this edge's write lands: read-before-write.
  always_comb begin
    rd_word  = mem[idx];
    rd_shift = rd_word >> {Address[1:0], 3'b000};
    case (Size)
      2'b00:   rd_ext = Unsigned ? {24'b0, rd_shift[7:0]}
                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = Unsigned ? {16'b0, rd_shift[15:0]}
                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  always_comb begin
    pv_d[0] = ld_ok;
    pd_d[0] = ld_ok ? rd_ext : pd_q[0];
    for (int i = 1; i < READ_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pv_q[i-1] ? pd_q[i-1] : pd_q[i];
    end
    mis_d = accept & mis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q  <= '0;
      mis_q <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) pd_q[i] <= '0;
    end else begin
      pv_q  <= pv_d;
      mis_q <= mis_d;
      for (int i = 0; i < READ_LAT; i++) pd_q[i] <= pd_d[i];
    end
  end

  assign DataOut    = pd_q[READ_LAT-1];
  assign Valid      = pv_q[READ_LAT-1];
  assign Misaligned = mis_q;
  assign Busy       = busy;
endmodule

// File: tb/tb_data_memory_ls.sv
// Directed bench for data_memory_ls (READ_LAT=1, DEPTH_WORDS=128).
// Build with DMEM_CLEAR_EN defined to also exercise the post-reset clear.
module tb_data_memory_ls;
  logic        clk;
  logic        rst_n;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic        W;
  logic        R;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] DataOut;
  logic        Valid;
  logic        Misaligned;
  logic        Busy;

  int total = 0;
  int bad   = 0;
  int n_busy;

  data_memory_ls #(.DEPTH_WORDS(128), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .Address(Address), .DataIn(DataIn),
    .W(W), .R(R), .Size(Size), .Unsigned(Unsigned),
    .DataOut(DataOut), .Valid(Valid), .Misaligned(Misaligned), .Busy(Busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: present a request, let one edge accept it, then idle the inputs
  task automatic op(input logic w, input logic r, input logic [1:0] sz,
                    input logic uns, input logic [31:0] addr, input logic [31:0] din);
    W = w; R = r; Size = sz; Unsigned = uns; Address = addr; DataIn = din;
    @(posedge clk); #1;
    W = 1'b0; R = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // count cycles Busy stays high while hammering a store that must be ignored
  task automatic count_busy(output int n);
    n = 0;
    W = 1'b1; R = 1'b0; Size = 2'b10; Address = 32'h10; DataIn = 32'hFFFF_FFFF;
    while (Busy && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (!Busy) W = 1'b0;
    end
    W = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; W = 1'b0; R = 1'b0; Size = 2'b10; Unsigned = 1'b0;
    Address = '0; DataIn = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, Valid}, 32'd0);
    chk("rst_mis", {31'b0, Misaligned}, 32'd0);
    chk("rst_dout", DataOut, 32'h0);
`ifdef DMEM_CLEAR_EN
    chk("rst_busy", {31'b0, Busy}, 32'd1);
    rst_n = 1'b1;
    count_busy(n_busy);
    chk("clear_len", n_busy, 32'd128);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("clear_ld10_v", {31'b0, Valid}, 32'd1);
    chk("clear_ld10", DataOut, 32'h0);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h1FC, 32'h0);
    chk("clear_ld1fc", DataOut, 32'h0);
    // restart mid-clear
    repeat (2) idle_cycle();
    rst_n = 1'b0;
    repeat (2) idle_cycle();
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    chk("rst50_busy", {31'b0, Busy}, 32'd1);
    idle_cycle();
    rst_n = 1'b1;
    count_busy(n_busy);
    chk("clear_restart_len", n_busy, 32'd128);
`else
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    rst_n = 1'b1;
    idle_cycle();
    chk("busy_idle", {31'b0, Busy}, 32'd0);
`endif

    // word store / load
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("st_word_nov", {31'b0, Valid}, 32'd0);
    chk("st_word_nomis", {31'b0, Misaligned}, 32'd0);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("ld_word_v", {31'b0, Valid}, 32'd1);
    chk("ld_word", DataOut, 32'hDEAD_BEEF);
    idle_cycle();
    chk("ld_word_pulse", {31'b0, Valid}, 32'd0);
    chk("dout_hold", DataOut, 32'hDEAD_BEEF);

    // byte store, signed / unsigned byte loads
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0000_0080);
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("ld_byte_s", DataOut, 32'hFFFF_FF80);
    op(1'b0, 1'b1, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("ld_byte_u", DataOut, 32'h0000_0080);
    op(1'b0, 1'b1, 2'b10, 1'b1, 32'h10, 32'h0);
    chk("ld_word_after_byte", DataOut, 32'h80AD_BEEF);

    // halves
    op(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("ld_half_s", DataOut, 32'hFFFF_80AD);
    op(1'b0, 1'b1, 2'b01, 1'b1, 32'h10, 32'h0);
    chk("ld_half_u", DataOut, 32'h0000_BEEF);
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("ld_byte1_s", DataOut, 32'hFFFF_FFBE);

    // misaligned
    op(1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0);
    chk("mis_half_pulse", {31'b0, Misaligned}, 32'd1);
    chk("mis_half_nov", {31'b0, Valid}, 32'd0);
    chk("mis_half_dout", DataOut, 32'hFFFF_FFBE);
    idle_cycle();
    chk("mis_half_one", {31'b0, Misaligned}, 32'd0);
    chk("mis_half_late_v", {31'b0, Valid}, 32'd0);
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h1234_5678);
    chk("mis_st_pulse", {31'b0, Misaligned}, 32'd1);
    op(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0);
    chk("mis_size11", {31'b0, Misaligned}, 32'd1);
    chk("mis_size11_nov", {31'b0, Valid}, 32'd0);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("mis_st_unchanged", DataOut, 32'h80AD_BEEF);

    // read-before-write, then next-cycle load sees the store
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h1111_1111);
    op(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h2222_2222);
    chk("rbw_v", {31'b0, Valid}, 32'd1);
    chk("rbw_old", DataOut, 32'h1111_1111);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("rbw_new", DataOut, 32'h2222_2222);

    // half store into upper lanes
    op(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'hABCD_1234);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("st_half_hi", DataOut, 32'h1234_2222);

    // address wrap modulo 512 bytes
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'hCAFE_F00D);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h000, 32'h0);
    chk("wrap", DataOut, 32'hCAFE_F00D);

    // back-to-back loads, one Valid per cycle
    W = 1'b0; R = 1'b1; Size = 2'b10; Unsigned = 1'b0;
    Address = 32'h10; @(posedge clk); #1;
    chk("b2b_0_v", {31'b0, Valid}, 32'd1);
    chk("b2b_0", DataOut, 32'h80AD_BEEF);
    Address = 32'h20; @(posedge clk); #1;
    chk("b2b_1_v", {31'b0, Valid}, 32'd1);
    chk("b2b_1", DataOut, 32'h1234_2222);
    Address = 32'h0; @(posedge clk); #1;
    chk("b2b_2_v", {31'b0, Valid}, 32'd1);
    chk("b2b_2", DataOut, 32'hCAFE_F00D);
    R = 1'b0;

    // async reset clears outputs, memory survives (unless cleared)
    rst_n = 1'b0;
    #1;
    chk("arst_v", {31'b0, Valid}, 32'd0);
    chk("arst_dout", DataOut, 32'h0);
    repeat (2) idle_cycle();
    rst_n = 1'b1;
`ifdef DMEM_CLEAR_EN
    count_busy(n_busy);
    chk("clear_len2", n_busy, 32'd128);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("post_rst_mem", DataOut, 32'h0);
`else
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("post_rst_mem", DataOut, 32'h80AD_BEEF);
`endif
    chk("post_rst_v", {31'b0, Valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_memory_ls.md
DATA_MEMORY_LS -- requirements
Module: data_memory_ls

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 128, meaning number of 32-bit words; power of two, 16..4096.
REQ-002 The block SHALL have parameter READ_LAT, default 1, meaning cycles from accepted read to Valid; legal 1..3.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port Address SHALL be an input, 32 bits: byte address.
REQ-006 Port DataIn SHALL be an input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 Port W SHALL be an input, 1 bit: store request.
REQ-008 Port R SHALL be an input, 1 bit: load request.
REQ-009 Port Size SHALL be an input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 Port Unsigned SHALL be an input, 1 bit: 1 zero-extends loads, 0 sign-extends.
REQ-011 Port DataOut SHALL be an output, 32 bits: extended load result.
REQ-012 Port Valid SHALL be an output, 1 bit: one-cycle pulse qualifying DataOut.
REQ-013 Port Misaligned SHALL be an output, 1 bit: one-cycle pulse flagging a rejected access.
REQ-014 Port Busy SHALL be an output, 1 bit: requests ignored while high.

Function
REQ-015 Word index SHALL be Address[log2(DEPTH_WORDS)+1:2]; higher bits ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-016 A request SHALL be accepted on a rising edge with (W|R)=1 and Busy=0.
REQ-017 Access SHALL be misaligned when Size=11, Size=01 with Address[0]=1, or Size=10 with Address[1:0]!=00.
REQ-018 A misaligned access SHALL not modify memory, SHALL produce no Valid, and SHALL pulse Misaligned exactly one cycle after acceptance.
REQ-019 An aligned store SHALL write only the addressed lanes: byte -> lane Address[1:0], half -> lanes {Address[1],0}+{0,1}, word -> all four; other lanes unchanged.
REQ-020 An aligned load SHALL pulse Valid exactly READ_LAT cycles after acceptance, with DataOut updated on that same edge.
REQ-021 Load data SHALL be the selected lane(s) shifted to bit 0, extended to 32 bits per Unsigned; Unsigned is ignored for word loads.
REQ-022 DataOut SHALL hold its last value between Valid pulses.
REQ-023 With W=1 and R=1 in one cycle, both SHALL execute; the load SHALL return pre-store contents (read-before-write).
REQ-024 A load accepted the cycle after a store to the same word SHALL return the new data.
REQ-025 Back-to-back loads SHALL be accepted every cycle; the pipeline SHALL sustain one Valid per cycle.

Reset
REQ-026 While rst_n=0, Valid=0, Misaligned=0, DataOut=0, and the read pipeline SHALL be emptied.
REQ-027 Loads in flight at reset assertion SHALL be dropped with no Valid.
REQ-028 Reset SHALL not alter memory contents except via the clear feature.
REQ-029 Busy SHALL be 1 during reset only when DMEM_CLEAR_EN is defined, and 0 otherwise.

Configuration
REQ-030 With DMEM_CLEAR_EN defined, the FSM SHALL have states CLEAR and IDLE; reset enters CLEAR with counter=0.
REQ-031 In CLEAR, the block SHALL zero one word per cycle, hold Busy=1, go to IDLE after word DEPTH_WORDS-1 is written, then drop Busy; Busy is high DEPTH_WORDS cycles after reset release.
REQ-032 Reset asserted during CLEAR SHALL restart the clear from word 0.
REQ-033 Without DMEM_CLEAR_EN, there SHALL be no FSM; Busy SHALL be tied 0, memory SHALL be uninitialised after power-up, and requests SHALL be accepted from the first edge after reset release.

Verification
REQ-034 Bench SHALL cover: store word 0xDEADBEEF @0x10, load word @0x10 -> Valid after READ_LAT cycles, DataOut=0xDEADBEEF.
REQ-035 Bench SHALL cover: store byte 0x80 @0x13, then load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word @0x10 -> 0x80ADBEEF.
REQ-036 Bench SHALL cover: load half @0x11 -> Misaligned pulse next cycle, no Valid; store word @0x12 -> memory unchanged.
REQ-037 Bench SHALL cover: W=R=1 @0x20, old 0x11111111, new 0x22222222 -> DataOut=0x11111111; next-cycle load -> 0x22222222.
REQ-038 Bench SHALL cover: DEPTH_WORDS=128, store @0x200 then load @0x000 -> same word (wrap).
REQ-039 Bench SHALL cover, with DMEM_CLEAR_EN: Busy high 128 cycles after reset release, requests ignored; afterwards any load returns 0; reset at cycle 50 restarts the 128-cycle clear.
